demux_router: RTL

Parametrised, registered 1-to-N demultiplexer with valid/ready handshaking on every port. A single input stream carries a payload and a channel select. Each beat is routed into a one-entry holding register on the selected output channel, or into all channels when broadcast is compiled in. The block is the sequential successor to the team's combinational 1x8 demux, sitting between a single producer and N independent consumers that may stall individually.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_slot.sv | 48 ++++
 rtl/demux_router.sv | 112 +++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the demux_router slice.
// Optional feature macro used by this slice: DEMUX_BCAST_EN (broadcast routing).
package demux_pkg;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  // True when a channel select addresses an existing output channel.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return (sel < n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single output channel.
// The slot reports itself free when empty or when it is being drained this
// cycle, so the producer can refill it back-to-back without a bubble.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             free
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign free      = ~full_q | ready_in;
  assign valid_out = full_q;
  assign data_out  = data_q;

  // Next slot state: drain clears, a load (which wins) fills.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q && ready_in) begin
      full_d = 1'b0;
    end
    if (load) begin
      full_d = 1'b1;
      data_d = data_in;
    end
  end

  // Slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/demux_router.sv
// demux_router: registered 1-to-N demultiplexer with per-channel valid/ready.
// Each channel owns a demux_slot; the top decodes the select, gates the input
// handshake and keeps the sticky error flag and saturating drop counter.
// Optional feature macro: DEMUX_BCAST_EN -- when defined, in_bcast=1 loads the
// beat into every slot at once; when undefined, in_bcast is ignored.
module demux_router
  import demux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_OUT = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   err,
  output logic [7:0]             drop_cnt
);

  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] load;
  logic             sel_ok;
  logic             drop;

  logic             err_q, err_d;
  drop_cnt_t        drop_q, drop_d;

  assign sel_ok = sel_in_range(32'(in_sel), N_OUT);

`ifndef DEMUX_BCAST_EN
  logic unused_bcast;
  assign unused_bcast = in_bcast;
`endif

  // Input handshake and slot load decode; in_ready never looks at in_valid.
  always_comb begin
    in_ready = 1'b1;
    load     = '0;
    drop     = 1'b0;
`ifdef DEMUX_BCAST_EN
    if (in_bcast) begin
      in_ready = &free;
      if (in_valid && in_ready) begin
        load = '1;
      end
    end else if (sel_ok) begin
      in_ready = free[in_sel];
      if (in_valid && in_ready) begin
        load[in_sel] = 1'b1;
      end
    end else begin
      drop = in_valid;
    end
`else
    if (sel_ok) begin
      in_ready = free[in_sel];
      if (in_valid && in_ready) begin
        load[in_sel] = 1'b1;
      end
    end else begin
      drop = in_valid;
    end
`endif
  end

  // One holding slot per output channel.
  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .data_in  (in_data),
      .ready_in (out_ready[k]),
      .valid_out(out_valid[k]),
      .data_out (out_data[k*WIDTH +: WIDTH]),
      .free     (free[k])
    );
  end

  // Sticky error and saturating drop count for out-of-range selects.
  always_comb begin
    err_d  = err_q | drop;
    drop_d = drop_q;
    if (drop && (drop_q != DROP_CNT_MAX)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  // Error/drop registers; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  assign err      = err_q;
  assign drop_cnt = drop_q;

endmodule
